// File: rtl/acm_scheduler_pkg.sv
// Shared definitions for the ACM read-address scheduler.
// Holds the operating-mode encoding that s_mode_i carries.
package p_hardisc;

  typedef enum logic [1:0] {
    ACM_MODE_OFF   = 2'b00,
    ACM_MODE_SWEEP = 2'b01,
    ACM_MODE_MIXED = 2'b10,
    ACM_MODE_PRIO  = 2'b11
  } acm_mode_e;

endpackage

// File: rtl/acm_susp_fifo.sv
// Suspect-address queue for the ACM scheduler: a circular buffer of
// QDEPTH x AW entries.
// Ports:
//   s_clk_i, s_resetn_i : clock, asynchronous active-low reset
//   s_clear_i           : drop all entries at the next edge
//   s_pop_i             : number of head entries removed this cycle (0..NRP)
//   s_push_i            : append s_push_add_i behind the remaining entries
//   s_entries_o         : entries in FIFO order, head in bits [AW-1:0]
//   s_count_o           : current occupancy
//   s_dup_o             : s_push_add_i equals a valid (pre-pop) entry
module acm_susp_fifo #(
  parameter int unsigned QDEPTH = 4,
  parameter int unsigned AW     = 5,
  parameter int unsigned NRP    = 2,
  parameter int unsigned CW     = $clog2(QDEPTH + 1),
  parameter int unsigned PW     = $clog2(NRP + 1)
) (
  input  logic                 s_clk_i,
  input  logic                 s_resetn_i,
  input  logic                 s_clear_i,
  input  logic [PW-1:0]        s_pop_i,
  input  logic                 s_push_i,
  input  logic [AW-1:0]        s_push_add_i,
  output logic [QDEPTH*AW-1:0] s_entries_o,
  output logic [CW-1:0]        s_count_o,
  output logic                 s_dup_o
);

  localparam int unsigned IW = $clog2(QDEPTH);

  logic [AW-1:0] mem [QDEPTH];
  logic [IW-1:0] r_head;
  logic [CW-1:0] r_count;
  logic [IW-1:0] tail;
  logic [IW-1:0] head_nxt;

  function automatic logic [IW-1:0] wrap_idx(input int unsigned i);
    return IW'(i % QDEPTH);
  endfunction

  always_comb begin
    s_entries_o = '0;
    s_dup_o     = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      s_entries_o[i*AW +: AW] = mem[wrap_idx(32'(r_head) + i)];
      if ((i < 32'(r_count)) && (mem[wrap_idx(32'(r_head) + i)] == s_push_add_i))
        s_dup_o = 1'b1;
    end
    // The tail slot does not move with a pop, so a push lands directly
    // behind whatever survives this cycle's pop.
    tail     = wrap_idx(32'(r_head) + 32'(r_count));
    head_nxt = wrap_idx(32'(r_head) + 32'(s_pop_i));
  end

  assign s_count_o = r_count;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_head  <= '0;
      r_count <= '0;
    end else if (s_clear_i) begin
      r_head  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= head_nxt;
      r_count <= r_count - CW'(s_pop_i) + CW'(s_push_i);
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (s_push_i && !s_clear_i)
      mem[tail] <= s_push_add_i;
  end

endmodule

// File: rtl/acm_scheduler.sv
// ACM read-address scheduler: gives every idle register-file read port a
// scrub address, taken from a suspect queue or from a sequential sweep.
// Ports:
//   s_clk_i, s_resetn_i : clock, asynchronous active-low reset
//   s_mode_i            : 00 off, 01 sweep, 10 sweep+priority, 11 priority-only
//   s_flush_i           : treat all ports as free this cycle
//   s_free_i            : per-port idle flags
//   s_susp_valid_i/add_i/ready_o : suspect-address report handshake
//   s_scrub_use_o       : per-port scrub enable
//   s_scrub_add_o       : per-port scrub address, port k in [k*AW +: AW]
//   s_scrub_pri_o       : per-port flag, address taken from the queue
//   s_qcount_o          : suspect-queue occupancy
module acm_scheduler
  import p_hardisc::*;
#(
  parameter int unsigned NRP       = 2,
  parameter int unsigned AW        = 5,
  parameter int unsigned FIRST_ADD = 1,
  parameter int unsigned QDEPTH    = 4
) (
  input  logic                           s_clk_i,
  input  logic                           s_resetn_i,
  input  logic [1:0]                     s_mode_i,
  input  logic                           s_flush_i,
  input  logic [NRP-1:0]                 s_free_i,
  input  logic                           s_susp_valid_i,
  input  logic [AW-1:0]                  s_susp_add_i,
  output logic                           s_susp_ready_o,
  output logic [NRP-1:0]                 s_scrub_use_o,
  output logic [NRP*AW-1:0]              s_scrub_add_o,
  output logic [NRP-1:0]                 s_scrub_pri_o,
  output logic [$clog2(QDEPTH+1)-1:0]    s_qcount_o
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned PW = $clog2(NRP + 1);

  if (NRP > (2 ** AW) - FIRST_ADD) begin : g_chk_nrp
    $error("acm_scheduler: NRP exceeds the number of scrubbable addresses");
  end
  if (QDEPTH < 2) begin : g_chk_qdepth
    $error("acm_scheduler: QDEPTH must be at least 2");
  end

  acm_mode_e            mode;
  logic [NRP-1:0]       free_eff;
  logic [AW-1:0]        r_add;
  logic [AW-1:0]        seq_cur;
  logic [AW-1:0]        add_nxt;
  logic [QDEPTH*AW-1:0] q_entries;
  logic [CW-1:0]        q_count;
  logic                 q_dup;
  logic [PW-1:0]        pop;
  logic                 push;
  logic                 use_queue;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] a);
    if (a == '1) return AW'(FIRST_ADD);
    return a + 1'b1;
  endfunction

  // Ports are scanned upward; pop doubles as the running count of queue
  // entries handed out so far and seq_cur as the running sweep address.
  always_comb begin
    mode          = acm_mode_e'(s_mode_i);
    free_eff      = s_flush_i ? '1 : s_free_i;
    use_queue     = (mode == ACM_MODE_MIXED) || (mode == ACM_MODE_PRIO);
    s_scrub_use_o = '0;
    s_scrub_pri_o = '0;
    s_scrub_add_o = '0;
    pop           = '0;
    seq_cur       = r_add;
    add_nxt       = r_add;
    if (mode != ACM_MODE_OFF) begin
      s_scrub_use_o = free_eff;
      for (int unsigned k = 0; k < NRP; k++) begin
        if (free_eff[k]) begin
          if (use_queue && (32'(pop) < 32'(q_count))) begin
            s_scrub_add_o[k*AW +: AW] = q_entries[32'(pop)*AW +: AW];
            s_scrub_pri_o[k]          = 1'b1;
            pop                       = pop + 1'b1;
          end else if (mode == ACM_MODE_PRIO) begin
            s_scrub_add_o[k*AW +: AW] = r_add;
          end else begin
            s_scrub_add_o[k*AW +: AW] = seq_cur;
            seq_cur                   = f_next(seq_cur);
          end
        end
      end
      if (mode != ACM_MODE_PRIO)
        add_nxt = seq_cur;
    end
  end

  assign s_susp_ready_o = s_resetn_i && (mode != ACM_MODE_OFF) && (q_count < CW'(QDEPTH));
  // Rejected reports (below FIRST_ADD or already queued) are still consumed.
  assign push = s_susp_valid_i && s_susp_ready_o &&
                (s_susp_add_i >= AW'(FIRST_ADD)) && !q_dup;
  assign s_qcount_o = q_count;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i)
      r_add <= AW'(FIRST_ADD);
    else
      r_add <= add_nxt;
  end

  acm_susp_fifo #(
    .QDEPTH (QDEPTH),
    .AW     (AW),
    .NRP    (NRP),
    .CW     (CW),
    .PW     (PW)
  ) u_fifo (
    .s_clk_i      (s_clk_i),
    .s_resetn_i   (s_resetn_i),
    .s_clear_i    (mode == ACM_MODE_OFF),
    .s_pop_i      (pop),
    .s_push_i     (push),
    .s_push_add_i (s_susp_add_i),
    .s_entries_o  (q_entries),
    .s_count_o    (q_count),
    .s_dup_o      (q_dup)
  );

endmodule

// File: tb/tb_acm_scheduler.sv
// Scoreboard bench for acm_scheduler: the stimulus process computes the
// expected outputs from a queue/pointer reference model and enqueues them;
// a monitor process samples the DUT and compares.
module tb_acm_scheduler;

  localparam int NRP = 2;
  localparam int AW  = 5;
  localparam int FA  = 1;
  localparam int QD  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      mode;
  logic            flush;
  logic [NRP-1:0]  free;
  logic            valid;
  logic [AW-1:0]   sadd;
  logic            ready;
  logic [NRP-1:0]  use_o;
  logic [NRP*AW-1:0] add_o;
  logic [NRP-1:0]  pri_o;
  logic [2:0]      qcount;

  always #5 clk = ~clk;

  acm_scheduler #(
    .NRP       (NRP),
    .AW        (AW),
    .FIRST_ADD (FA),
    .QDEPTH    (QD)
  ) dut (
    .s_clk_i        (clk),
    .s_resetn_i     (rst_n),
    .s_mode_i       (mode),
    .s_flush_i      (flush),
    .s_free_i       (free),
    .s_susp_valid_i (valid),
    .s_susp_add_i   (sadd),
    .s_susp_ready_o (ready),
    .s_scrub_use_o  (use_o),
    .s_scrub_add_o  (add_o),
    .s_scrub_pri_o  (pri_o),
    .s_qcount_o     (qcount)
  );

  typedef struct {
    logic [NRP-1:0]    use_v;
    logic [NRP-1:0]    pri;
    logic [NRP*AW-1:0] add;
    logic              rdy;
    logic [2:0]        qc;
  } exp_t;

  exp_t sbq[$];
  int   mq[$];
  int   ptr = FA;
  int   errors = 0;
  int   checks = 0;

  function automatic int nxt(input int a);
    return (a == (1 << AW) - 1) ? FA : a + 1;
  endfunction

  task automatic drive(input bit rst, input int m, input bit fl,
                       input logic [NRP-1:0] fr, input bit v, input int a);
    exp_t e;
    int   flist[$];
    logic [NRP-1:0] f;
    int   nq;
    int   p;
    int   k;
    int   tmp;
    bit   dup;
    @(negedge clk);
    rst_n = rst;
    mode  = m[1:0];
    flush = fl;
    free  = fr;
    valid = v;
    sadd  = a[AW-1:0];
    if (!rst) begin
      mq.delete();
      ptr = FA;
    end
    f = fl ? '1 : fr;
    e.use_v = '0;
    e.pri   = '0;
    e.add   = '0;
    for (int i = 0; i < NRP; i++)
      if (f[i]) flist.push_back(i);
    nq = 0;
    if (m >= 2) nq = (mq.size() < flist.size()) ? mq.size() : flist.size();
    p = ptr;
    if (m != 0) begin
      e.use_v = f;
      for (int j = 0; j < flist.size(); j++) begin
        k = flist[j];
        if (j < nq) begin
          tmp = mq[j];
          e.add[k*AW +: AW] = tmp[AW-1:0];
          e.pri[k] = 1'b1;
        end else if (m == 3) begin
          e.add[k*AW +: AW] = ptr[AW-1:0];
        end else begin
          e.add[k*AW +: AW] = p[AW-1:0];
          p = nxt(p);
        end
      end
    end
    e.rdy = rst && (m != 0) && (mq.size() < QD);
    e.qc  = 3'(mq.size());
    sbq.push_back(e);
    if (rst) begin
      if (m == 0) begin
        mq.delete();
      end else begin
        dup = 1'b0;
        foreach (mq[i]) if (mq[i] == a) dup = 1'b1;
        if (m != 3) ptr = p;
        repeat (nq) void'(mq.pop_front());
        if (v && e.rdy && (a >= FA) && !dup) mq.push_back(a);
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if (use_o !== e.use_v) begin
          errors++;
          $display("FAIL use: got %b exp %b at %0t", use_o, e.use_v, $time);
        end
        checks++;
        if (pri_o !== e.pri) begin
          errors++;
          $display("FAIL pri: got %b exp %b at %0t", pri_o, e.pri, $time);
        end
        for (int k = 0; k < NRP; k++) begin
          if (e.use_v[k]) begin
            checks++;
            if (add_o[k*AW +: AW] !== e.add[k*AW +: AW]) begin
              errors++;
              $display("FAIL add%0d: got %0d exp %0d at %0t", k,
                       add_o[k*AW +: AW], e.add[k*AW +: AW], $time);
            end
          end
        end
        checks++;
        if (ready !== e.rdy) begin
          errors++;
          $display("FAIL ready: got %b exp %b at %0t", ready, e.rdy, $time);
        end
        checks++;
        if (qcount !== e.qc) begin
          errors++;
          $display("FAIL qcount: got %0d exp %0d at %0t", qcount, e.qc, $time);
        end
      end
    end
  end

  initial begin
    int m;
    int a;
    int small_set[5];
    small_set = '{0, 1, 5, 9, 31};
    rst_n = 1'b0; mode = 2'b00; flush = 1'b0; free = '0; valid = 1'b0; sadd = '0;

    repeat (2) drive(0, 1, 0, 2'b11, 0, 0);
    // sweep from reset, wrap through 31 -> 1
    repeat (15) drive(1, 1, 0, 2'b11, 0, 0);
    drive(1, 1, 0, 2'b10, 0, 0);
    drive(1, 1, 0, 2'b00, 0, 0);
    repeat (2) drive(1, 1, 0, 2'b11, 0, 0);
    // priority pushes and issue
    drive(1, 2, 0, 2'b00, 1, 7);
    drive(1, 2, 0, 2'b00, 1, 12);
    drive(1, 2, 0, 2'b01, 0, 0);
    drive(1, 2, 0, 2'b11, 0, 0);
    // duplicates, below-FIRST_ADD, full queue
    repeat (3) drive(1, 2, 0, 2'b00, 1, 9);
    drive(1, 2, 0, 2'b00, 1, 0);
    drive(1, 2, 0, 2'b00, 1, 20);
    drive(1, 2, 0, 2'b00, 1, 21);
    drive(1, 2, 0, 2'b00, 1, 22);
    drive(1, 2, 0, 2'b11, 1, 23);
    // priority-only, empty queue, flush pop
    repeat (3) drive(1, 3, 0, 2'b11, 0, 0);
    drive(1, 3, 0, 2'b00, 1, 5);
    drive(1, 3, 1, 2'b00, 0, 0);
    // reset with a partly filled queue
    drive(1, 2, 0, 2'b00, 1, 17);
    drive(1, 2, 0, 2'b00, 1, 18);
    drive(1, 2, 0, 2'b00, 1, 19);
    drive(0, 2, 0, 2'b11, 1, 4);
    drive(0, 2, 0, 2'b00, 0, 0);
    repeat (2) drive(1, 1, 0, 2'b11, 0, 0);
    // mode off clears the queue
    drive(1, 2, 0, 2'b00, 1, 6);
    drive(1, 0, 0, 2'b11, 1, 8);
    drive(1, 2, 0, 2'b11, 0, 0);

    m = 2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) m = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      a = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : small_set[$urandom_range(0, 4)];
      drive($urandom_range(0, 199) != 0, m, $urandom_range(0, 15) == 0,
            NRP'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, a);
    end

    repeat (4) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending exp 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
